// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the memory-access stage.
//   memop_t      : operation class presented by EX (none / load / store)
//   F3_*         : funct3 encodings for loads and stores
//   ma_state_t   : memory-access FSM states
//   mem_size()   : funct3 -> log2(access bytes)
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } memop_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_WAIT = 2'd2
  } ma_state_t;

  // Low two funct3 bits encode the access size for both loads and stores;
  // bit 2 only selects zero-extension on loads.
  function automatic logic [1:0] mem_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage

// File: rtl/riscv_ma_align.sv
// riscv_ma_align: combinational lane logic for the memory-access stage.
//   funct3_i : access size/sign
//   off_i    : byte offset inside the bus word (already size-aligned)
//   sdata_i  : store operand (rs2)
//   rdata_i  : full bus word returned by the memory
//   be_o     : byte enables for the access
//   wdata_o  : store data replicated across all lanes of its size
//   ldata_o  : load data shifted down and sign/zero-extended
module riscv_ma_align import riscv_pkg::*; #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OB   = $clog2(NB)
) (
  input  logic [2:0]      funct3_i,
  input  logic [OB-1:0]   off_i,
  input  logic [XLEN-1:0] sdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [1:0]      sz;
  logic [6:0]      nbits;
  logic [XLEN-1:0] shifted, mask;
  logic            sgn;

  assign sz = mem_size(funct3_i);

  // Byte i takes operand byte (i mod size): narrow stores land in every lane
  // of their size, so the enabled lanes always see the right bytes.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    for (int i = 0; i < NB; i++) begin
      wdata_o[i*8 +: 8] = sdata_i[(i & ((1 << sz) - 1))*8 +: 8];
      be_o[i]           = (i >= int'(off_i)) && (i < int'(off_i) + (1 << sz));
    end
  end

  // mask covers the access width; full-width accesses shift it to all ones,
  // which makes the extension a no-op without special-casing.
  assign nbits   = 7'd8 << sz;
  assign shifted = rdata_i >> {off_i, 3'b000};
  assign mask    = ~({XLEN{1'b1}} << nbits);
  assign sgn     = ~funct3_i[2] & (|(shifted & mask & ~(mask >> 1)));
  assign ldata_o = (shifted & mask) | ({XLEN{sgn}} & ~mask);

endmodule

// File: rtl/riscv_ma_lsu.sv
// riscv_ma_lsu: memory-access pipeline stage with a req/gnt/rvalid data bus.
// Optional feature macro: RISCV_MA_MISALIGN_TRAP_EN (adds misalign output and
// traps unaligned accesses; otherwise the offset is force-aligned).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          op handshake from EX (ready only in IDLE)
//   memop, funct3, resi,
//   sdata, rdi                 op class, size/sign, ALU result/address,
//                              store data, destination register
//   dmem_req/we/addr/be/wdata  registered bus request, held until dmem_gnt
//   dmem_gnt/rvalid/rdata      bus grant, read-valid and read data
//   out_valid, rd, res         one-cycle writeback pulse, register, value
//   misalign                   trap flag (only with the macro defined)
module riscv_ma_lsu import riscv_pkg::*; #(
  parameter  int XLEN = 32,
  parameter  int REGN = 32,
  localparam int REGA = $clog2(REGN),
  localparam int NB   = XLEN / 8,
  localparam int OB   = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      memop,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] resi,
  input  logic [XLEN-1:0] sdata,
  input  logic [REGA-1:0] rdi,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [NB-1:0]   dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  output logic [REGA-1:0] rd,
  output logic [XLEN-1:0] res
`ifdef RISCV_MA_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  ma_state_t       state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [NB-1:0]   be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [OB-1:0]   off_q, off_d;
  logic [REGA-1:0] rdl_q, rdl_d, rd_q, rd_d;
  logic            ov_q, ov_d;
  logic [XLEN-1:0] res_q, res_d;
`ifdef RISCV_MA_MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
  logic            misal_in;
`endif

  memop_t          mop;
  logic [OB-1:0]   off_in, lo_mask, off_al, al_off;
  logic [2:0]      al_f3;
  logic [NB-1:0]   al_be;
  logic [XLEN-1:0] al_wdata, al_ldata;

  assign mop     = memop_t'(memop);
  assign off_in  = resi[OB-1:0];
  assign lo_mask = ~({OB{1'b1}} << mem_size(funct3));
  assign off_al  = off_in & ~lo_mask;
`ifdef RISCV_MA_MISALIGN_TRAP_EN
  assign misal_in = |(off_in & lo_mask);
`endif

  // One aligner serves both directions: store lanes are formed from the live
  // EX op at accept time, load extraction uses the latched op while waiting.
  assign al_f3  = (state_q == MA_IDLE) ? funct3 : f3_q;
  assign al_off = (state_q == MA_IDLE) ? off_al : off_q;

  riscv_ma_align #(.XLEN(XLEN)) u_align (
    .funct3_i (al_f3),
    .off_i    (al_off),
    .sdata_i  (sdata),
    .rdata_i  (dmem_rdata),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .ldata_o  (al_ldata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdl_d   = rdl_q;
    ov_d    = 1'b0;
    rd_d    = rd_q;
    res_d   = res_q;
`ifdef RISCV_MA_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      MA_IDLE: begin
        if (in_valid) begin
          if (mop == MEM_LOAD || mop == MEM_STORE) begin
`ifdef RISCV_MA_MISALIGN_TRAP_EN
            if (misal_in) begin
              ov_d  = 1'b1;
              mis_d = 1'b1;
              rd_d  = '0;
              res_d = resi;
            end else
`endif
            begin
              state_d = MA_REQ;
              req_d   = 1'b1;
              we_d    = (mop == MEM_STORE);
              addr_d  = {resi[XLEN-1:OB], {OB{1'b0}}};
              be_d    = al_be;
              wdata_d = al_wdata;
              f3_d    = funct3;
              off_d   = off_al;
              rdl_d   = rdi;
            end
          end else begin
            ov_d  = 1'b1;
            rd_d  = rdi;
            res_d = resi;
          end
        end
      end
      MA_REQ: begin
        if (dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = MA_IDLE;
            ov_d    = 1'b1;
            rd_d    = '0;
            res_d   = '0;
          end else begin
            state_d = MA_WAIT;
          end
        end
      end
      MA_WAIT: begin
        if (dmem_rvalid) begin
          state_d = MA_IDLE;
          ov_d    = 1'b1;
          rd_d    = rdl_q;
          res_d   = al_ldata;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MA_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdl_q   <= '0;
      ov_q    <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
`ifdef RISCV_MA_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdl_q   <= rdl_d;
      ov_q    <= ov_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
`ifdef RISCV_MA_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign in_ready   = (state_q == MA_IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign out_valid  = ov_q;
  assign rd         = rd_q;
  assign res        = res_q;
`ifdef RISCV_MA_MISALIGN_TRAP_EN
  assign misalign   = mis_q;
`endif

endmodule

// File: tb/tb_riscv_ma_lsu.sv
// tb_riscv_ma_lsu: self-checking bench for riscv_ma_lsu (XLEN=32).
// Build with RISCV_MA_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_riscv_ma_lsu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  memop;
  logic [2:0]  funct3;
  logic [31:0] resi, sdata;
  logic [4:0]  rdi;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        out_valid;
  logic [4:0]  rd;
  logic [31:0] res;
`ifdef RISCV_MA_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  riscv_ma_lsu #(.XLEN(32), .REGN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .memop(memop), .funct3(funct3), .resi(resi), .sdata(sdata), .rdi(rdi),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .rd(rd), .res(res)
`ifdef RISCV_MA_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the cycle following the next rising edge.
  logic        e_ready, e_valid, e_req, e_we, e_mis;
  logic [4:0]  e_rd;
  logic [31:0] e_res, e_addr, e_wdata;
  logic [3:0]  e_be;

  // First-REQ-cycle snapshot of the bus request for literal checks.
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  logic [2:0] ldf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- reference model: access rules in plain arithmetic ----
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int eff_off(input logic [31:0] a, input logic [2:0] f3);
    int o;
    o = int'(a % 4);
    return o - (o % nbytes(f3));
  endfunction

  function automatic logic [3:0] m_be(input int n, input int o);
    int m;
    m = ((1 << n) - 1) << o;
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] s);
    case (n)
      1:       return {4{s[7:0]}};
      2:       return {2{s[15:0]}};
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int o, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * o);
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd4:    return {24'd0, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // ---- compare process: every cycle, just after the rising edge ----
  always @(posedge clk) begin
    #1;
    chk("in_ready", 64'(in_ready), 64'(e_ready));
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("dmem_req", 64'(dmem_req), 64'(e_req));
    if (e_valid) begin
      chk("rd", 64'(rd), 64'(e_rd));
      chk("res", 64'(res), 64'(e_res));
`ifdef RISCV_MA_MISALIGN_TRAP_EN
      chk("misalign", 64'(misalign), 64'(e_mis));
`endif
    end
    if (e_req) begin
      chk("dmem_we", 64'(dmem_we), 64'(e_we));
      chk("dmem_addr", 64'(dmem_addr), 64'(e_addr));
      chk("dmem_be", 64'(dmem_be), 64'(e_be));
      if (e_we) chk("dmem_wdata", 64'(dmem_wdata), 64'(e_wdata));
    end
  end

  // Runs one op end to end; the bench plays the memory slave. Returns at the
  // falling edge inside the out_valid cycle (outputs still showing it).
  task automatic do_op(input logic [1:0] mop, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] r, input logic [31:0] rdat,
                       input int gd, input int rv, input bit hold);
    int n, o;
    n = nbytes(f3);
    o = eff_off(a, f3);
    @(negedge clk);
    in_valid = 1'b1; memop = mop; funct3 = f3; resi = a; sdata = sd; rdi = r;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    e_valid = 1'b0; e_mis = 1'b0; e_req = 1'b0; e_ready = 1'b1;
    if (mop != MEM_LOAD && mop != MEM_STORE) begin
      e_valid = 1'b1; e_res = a; e_rd = r;
    end
`ifdef RISCV_MA_MISALIGN_TRAP_EN
    else if (((a % 4) % n) != 0) begin
      e_valid = 1'b1; e_mis = 1'b1; e_res = a; e_rd = 5'd0;
    end
`endif
    else begin
      e_ready = 1'b0; e_req = 1'b1; e_we = (mop == MEM_STORE);
      e_addr = {a[31:2], 2'b00}; e_be = m_be(n, o); e_wdata = m_wdata(n, sd);
      @(negedge clk);
      cap_we = dmem_we; cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata;
      // Optionally keep a different op pending; it must not be taken while busy.
      in_valid = hold;
      if (hold) begin
        memop = 2'($urandom_range(0, 2)); funct3 = 3'($urandom);
        resi = $urandom; rdi = 5'($urandom);
      end
      for (int k = 0; k < gd; k++) begin
        dmem_rvalid = 1'($urandom);   // stray rvalid while requesting is ignored
        dmem_rdata  = $urandom;
        @(negedge clk);
      end
      dmem_rvalid = 1'b0; dmem_gnt = 1'b1; e_req = 1'b0;
      if (mop == MEM_STORE) begin
        e_ready = 1'b1; e_valid = 1'b1; e_rd = 5'd0; e_res = 32'd0;
      end else begin
        @(negedge clk);
        dmem_gnt = 1'b0;
        for (int k = 0; k < rv; k++) @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = rdat;
        e_ready = 1'b1; e_valid = 1'b1; e_rd = r; e_res = m_load(f3, o, rdat);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    e_valid = 1'b0; e_mis = 1'b0; e_req = 1'b0; e_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; memop = 2'd0; funct3 = 3'd0; resi = '0; sdata = '0;
    rdi = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    e_ready = 1'b1; e_valid = 1'b0; e_req = 1'b0; e_we = 1'b0; e_mis = 1'b0;
    e_rd = '0; e_res = '0; e_addr = '0; e_wdata = '0; e_be = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_be", 64'(dmem_be), 64'd0);
    rst_n = 1'b1;

    // 1: pass-through, latency 1
    do_op(MEM_NONE, 3'd0, 32'h1234, 32'h0, 5'd5, 32'h0, 0, 0, 1'b0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_res", 64'(res), 64'h1234);
    chk("t1_rd", 64'(rd), 64'd5);

    // 2: LB / LBU on the top byte, gnt after 2 cycles, EX op held while busy
    do_op(MEM_LOAD, 3'd0, 32'h103, 32'h0, 5'd7, 32'h80FF_0000, 2, 0, 1'b1);
    chk("t2_lb_res", 64'(res), 64'hFFFF_FF80);
    chk("t2_lb_rd", 64'(rd), 64'd7);
    do_op(MEM_LOAD, 3'd4, 32'h103, 32'h0, 5'd7, 32'h80FF_0000, 2, 0, 1'b1);
    chk("t2_lbu_res", 64'(res), 64'h0000_0080);

    // 3: SH to the upper half
    do_op(MEM_STORE, 3'd1, 32'h102, 32'hABCD, 5'd3, 32'h0, 1, 0, 1'b0);
    chk("t3_be", 64'(cap_be), 64'hC);
    chk("t3_wdata_hi", 64'(cap_wdata[31:16]), 64'hABCD);
    chk("t3_we", 64'(cap_we), 64'd1);
    chk("t3_rd", 64'(rd), 64'd0);
    chk("t3_valid", 64'(out_valid), 64'd1);

    // 6: misaligned LW
    do_op(MEM_LOAD, 3'd2, 32'h101, 32'h0, 5'd4, 32'h1122_3344, 0, 1, 1'b0);
`ifdef RISCV_MA_MISALIGN_TRAP_EN
    chk("t6_mis", 64'(misalign), 64'd1);
    chk("t6_res", 64'(res), 64'h101);
    chk("t6_rd", 64'(rd), 64'd0);
    chk("t6_noreq", 64'(dmem_req), 64'd0);
`else
    chk("t6_addr", 64'(cap_addr), 64'h100);
    chk("t6_be", 64'(cap_be), 64'hF);
    chk("t6_res", 64'(res), 64'h1122_3344);
`endif

    // 5: reset asserted while in REQ
    @(negedge clk);
    in_valid = 1'b1; memop = MEM_LOAD; funct3 = 3'd2; resi = 32'h200; rdi = 5'd9;
    e_ready = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h200; e_be = 4'hF; e_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    e_req = 1'b0; e_ready = 1'b1; e_valid = 1'b0;
    #1;
    chk("t5_req_drop", 64'(dmem_req), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic [1:0] m;
      logic [2:0] f;
      m = 2'($urandom_range(0, 2));
      if (m == MEM_LOAD) f = ldf3[$urandom_range(0, 4)];
      else               f = 3'($urandom_range(0, 2));
      do_op(m, f, $urandom, $urandom, 5'($urandom), $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
